// File: rtl/dbus_bridge_pkg.sv
// Shared bexkat1 definitions used by the data-bus bridge.
// State encoding and Wishbone lane-select constants.
package bexkat1Def;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE
  } dbus_state_t;

  localparam logic [3:0] SEL_WORD = 4'hf;
  localparam logic [3:0] SEL_HI   = 4'b1100;
  localparam logic [3:0] SEL_LO   = 4'b0011;

endpackage

// File: rtl/dbus_bridge_lane.sv
// Lane logic: store replication, load right-justification and
// big-endian lane-select legality check.
module dbus_lane
  import bexkat1Def::*;
(
  input  logic [3:0]  wsel_i,
  input  logic [31:0] wdat_i,
  input  logic [3:0]  rsel_i,
  input  logic [31:0] rdat_i,
  output logic        legal_o,
  output logic [31:0] wdat_o,
  output logic [31:0] rdat_o
);

  always_comb begin
    legal_o = 1'b1;
    wdat_o  = '0;
    unique case (wsel_i)
      4'b1000, 4'b0100,
      4'b0010, 4'b0001: wdat_o = {4{wdat_i[7:0]}};
      SEL_HI, SEL_LO:   wdat_o = {2{wdat_i[15:0]}};
      SEL_WORD:         wdat_o = wdat_i;
      default:          legal_o = 1'b0;
    endcase
  end

  // Lane 0 of the select is bits 31:24 (big-endian bus).
  always_comb begin
    rdat_o = '0;
    unique case (rsel_i)
      4'b1000:  rdat_o = {24'b0, rdat_i[31:24]};
      4'b0100:  rdat_o = {24'b0, rdat_i[23:16]};
      4'b0010:  rdat_o = {24'b0, rdat_i[15:8]};
      4'b0001:  rdat_o = {24'b0, rdat_i[7:0]};
      SEL_HI:   rdat_o = {16'b0, rdat_i[31:16]};
      SEL_LO:   rdat_o = {16'b0, rdat_i[15:0]};
      SEL_WORD: rdat_o = rdat_i;
      default:  rdat_o = '0;
    endcase
  end

endmodule

// File: rtl/dbus_bridge.sv
// bexkat1 memory stage to pipelined Wishbone data-bus bridge.
// Optional watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_bridge
  import bexkat1Def::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_cyc_i,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_dat_i,
  output logic        req_ack_o,
  output logic        req_err_o,
  output logic [31:0] req_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);

  dbus_state_t state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;

  logic        legal;
  logic [31:0] wrep;
  logic [31:0] ralign;
  logic        busy;
  logic        rsp;
  logic        to_hit;
  logic [1:0]  unused_adr;

  assign unused_adr = req_adr_i[1:0];

  dbus_lane u_lane (
    .wsel_i  (req_sel_i),
    .wdat_i  (req_dat_i),
    .rsel_i  (sel_q),
    .rdat_i  (wb_dat_i),
    .legal_o (legal),
    .wdat_o  (wrep),
    .rdat_o  (ralign)
  );

  assign busy = (state_q == ADDR) || (state_q == WAIT);
  assign rsp  = ((state_q == ADDR) && !wb_stall_i)
             || (state_q == WAIT);

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign to_hit = busy && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (busy) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT);
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_cyc_i) state_d = legal ? ADDR : DONE;
      ADDR: begin
        if (!wb_stall_i) begin
          state_d = (wb_ack_i || wb_err_i) ? DONE : WAIT;
        end
      end
      WAIT: if (wb_ack_i || wb_err_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_hit) state_d = DONE;
  end

  always_comb begin
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    abort_d = abort_q;
    if (state_q == IDLE && req_cyc_i) begin
      we_d    = req_we_i;
      adr_d   = req_adr_i[31:2];
      sel_d   = req_sel_i;
      wdat_d  = wrep;
      rdat_d  = '0;
      err_d   = !legal;
      abort_d = 1'b0;
    end
    if (busy && !req_cyc_i) abort_d = 1'b1;
    // Error wins over ack; error completions carry zero data.
    if (rsp && wb_err_i) begin
      err_d  = 1'b1;
      rdat_d = '0;
    end else if (rsp && wb_ack_i) begin
      rdat_d = ralign;
    end
    if (to_hit) begin
      err_d  = 1'b1;
      rdat_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    wb_cyc_o  = busy;
    wb_stb_o  = (state_q == ADDR);
    wb_we_o   = we_q;
    wb_adr_o  = {adr_q, 2'b00};
    wb_sel_o  = sel_q;
    wb_dat_o  = wdat_q;
    req_ack_o = (state_q == DONE) && !abort_q;
    req_err_o = req_ack_o && err_q;
    req_dat_o = req_ack_o ? rdat_q : '0;
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: vector table plus
// hand sequences for stalls, errors, abort, hang and reset.
module tb_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_cyc_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_adr_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic [31:0] req_dat_i = '0;
  logic        req_ack_o;
  logic        req_err_o;
  logic [31:0] req_dat_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_stall_i = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  int checks = 0;
  int errors = 0;

  dbus_bridge #(.TIMEOUT(8)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_cyc_i  (req_cyc_i),
    .req_we_i   (req_we_i),
    .req_adr_i  (req_adr_i),
    .req_sel_i  (req_sel_i),
    .req_dat_i  (req_dat_i),
    .req_ack_o  (req_ack_o),
    .req_err_o  (req_err_o),
    .req_dat_o  (req_dat_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_stall_i (wb_stall_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_dat_i   (wb_dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] sd;
    logic [31:0] e_adr;
    logic [31:0] e_wdat;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    int          e_stb;
  } vec_t;

  // Request issued at a negedge in cycle N; cycle N+k sampled at
  // posedge k + 1.  Slave stalls nstall stb cycles, then responds
  // ackdly cycles after acceptance (0 = same cycle).
  task automatic run_txn(
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [3:0]  sel,
    input  logic [31:0] wd,
    input  logic [31:0] sd,
    input  int          nstall,
    input  int          ackdly,
    input  bit          use_err,
    input  bit          hang,
    input  int          abort_k,
    input  int          limit,
    output int          ack_k,
    output int          acks,
    output int          stbs,
    output logic        err,
    output logic [31:0] rd,
    output logic [31:0] badr,
    output logic [31:0] bdat,
    output logic        bwe,
    output logic [3:0]  bsel
  );
    bit acc;
    int acc_k;
    acc = 0; acc_k = -100;
    ack_k = -1; acks = 0; stbs = 0;
    err = 1'b0; rd = '0; badr = '0;
    bdat = '0; bwe = 1'b0; bsel = '0;
    @(negedge clk);
    req_cyc_i = 1'b1;
    req_we_i  = we;
    req_adr_i = adr;
    req_sel_i = sel;
    req_dat_i = wd;
    wb_dat_i  = sd;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (k == abort_k) req_cyc_i = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_stall_i = 1'b0;
      if (req_ack_o) begin
        acks++;
        if (ack_k < 0) ack_k = k;
        err = req_err_o;
        rd  = req_dat_o;
        req_cyc_i = 1'b0;
      end
      if (wb_stb_o) begin
        stbs++;
        badr = wb_adr_o;
        bdat = wb_dat_o;
        bwe  = wb_we_o;
        bsel = wb_sel_o;
        if (stbs <= nstall) wb_stall_i = 1'b1;
        else begin
          acc = 1;
          acc_k = k;
        end
      end
      if (acc && !hang && k == acc_k + ackdly) begin
        if (use_err) wb_err_i = 1'b1;
        else         wb_ack_i = 1'b1;
      end
      if (req_ack_o) break;
    end
    @(posedge clk); #1;
    if (req_ack_o) acks++;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_stall_i = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    int ack_k, acks, stbs;
    logic err, bwe;
    logic [31:0] rd, badr, bdat;
    logic [3:0] bsel;

    vecs[0] = '{"ld_word", 1'b0, 32'h100, 4'hf, 32'h0,
                32'hDEADBEEF, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1};
    vecs[1] = '{"ld_byte1", 1'b0, 32'h201, 4'b0100, 32'h0,
                32'h11223344, 32'h200, 32'h0, 32'h22, 1'b0, 3, 1};
    vecs[2] = '{"st_half", 1'b1, 32'h302, 4'b0011, 32'hAAAA1234,
                32'h0, 32'h300, 32'h12341234, 32'h0, 1'b0, 3, 1};
    vecs[3] = '{"st_byte", 1'b1, 32'h400, 4'b1000, 32'h0000005A,
                32'h0, 32'h400, 32'h5A5A5A5A, 32'h0, 1'b0, 3, 1};
    vecs[4] = '{"ld_hi", 1'b0, 32'h504, 4'b1100, 32'h0,
                32'hCAFEF00D, 32'h504, 32'h0, 32'h0000CAFE, 1'b0, 3, 1};
    vecs[5] = '{"ld_byte3", 1'b0, 32'h607, 4'b0001, 32'h0,
                32'h11223344, 32'h604, 32'h0, 32'h44, 1'b0, 3, 1};
    vecs[6] = '{"st_word", 1'b1, 32'h70C, 4'hf, 32'h01234567,
                32'h0, 32'h70C, 32'h01234567, 32'h0, 1'b0, 3, 1};
    vecs[7] = '{"bad_0101", 1'b0, 32'h800, 4'b0101, 32'h0,
                32'h55555555, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0};
    vecs[8] = '{"bad_0000", 1'b0, 32'h900, 4'b0000, 32'h0,
                32'h55555555, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wb_stb_o), 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_ack", 32'(req_ack_o), 32'h0);
    chk("rst_rdat", req_dat_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wd,
              vecs[i].sd, 0, 1, 0, 0, -1, 12,
              ack_k, acks, stbs, err, rd, badr, bdat, bwe, bsel);
      chk({vecs[i].nm, "_lat"}, 32'(ack_k), 32'(vecs[i].e_lat));
      chk({vecs[i].nm, "_acks"}, 32'(acks), 32'd1);
      chk({vecs[i].nm, "_stbs"}, 32'(stbs), 32'(vecs[i].e_stb));
      chk({vecs[i].nm, "_err"}, 32'(err), 32'(vecs[i].e_err));
      chk({vecs[i].nm, "_rd"}, rd, vecs[i].e_rd);
      if (vecs[i].e_stb != 0) begin
        chk({vecs[i].nm, "_adr"}, badr, vecs[i].e_adr);
        chk({vecs[i].nm, "_sel"}, 32'(bsel), 32'(vecs[i].sel));
        chk({vecs[i].nm, "_we"}, 32'(bwe), 32'(vecs[i].we));
        if (vecs[i].we)
          chk({vecs[i].nm, "_wdat"}, bdat, vecs[i].e_wdat);
      end
    end

    run_txn(1'b0, 32'hA00, 4'hf, 32'h0, 32'h13579BDF, 3, 2, 0, 0,
            -1, 20, ack_k, acks, stbs, err, rd, badr, bdat, bwe, bsel);
    chk("stall_stbs", 32'(stbs), 32'd4);
    chk("stall_acks", 32'(acks), 32'd1);
    chk("stall_lat", 32'(ack_k), 32'd7);
    chk("stall_rd", rd, 32'h13579BDF);

    run_txn(1'b0, 32'hB00, 4'hf, 32'h0, 32'hFFFFFFFF, 0, 1, 1, 0,
            -1, 12, ack_k, acks, stbs, err, rd, badr, bdat, bwe, bsel);
    chk("buserr_lat", 32'(ack_k), 32'd3);
    chk("buserr_err", 32'(err), 32'h1);
    chk("buserr_rd", rd, 32'h0);

    run_txn(1'b0, 32'hC00, 4'b0010, 32'h0, 32'h0000AB00, 0, 0, 0, 0,
            -1, 12, ack_k, acks, stbs, err, rd, badr, bdat, bwe, bsel);
    chk("fastack_lat", 32'(ack_k), 32'd2);
    chk("fastack_rd", rd, 32'h000000AB);

    run_txn(1'b0, 32'hD00, 4'hf, 32'h0, 32'h12345678, 0, 2, 0, 0,
            2, 6, ack_k, acks, stbs, err, rd, badr, bdat, bwe, bsel);
    chk("abort_acks", 32'(acks), 32'd0);
    chk("abort_stbs", 32'(stbs), 32'd1);
    chk("abort_cyc", 32'(wb_cyc_o), 32'h0);

    run_txn(1'b0, 32'hE00, 4'hf, 32'h0, 32'h87654321, 0, 1, 0, 1,
            -1, 20, ack_k, acks, stbs, err, rd, badr, bdat, bwe, bsel);
`ifdef DBUS_TIMEOUT_EN
    chk("to_lat", 32'(ack_k), 32'd9);
    chk("to_acks", 32'(acks), 32'd1);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rd", rd, 32'h0);
    chk("to_cyc", 32'(wb_cyc_o), 32'h0);
`else
    chk("hang_acks", 32'(acks), 32'd0);
    chk("hang_cyc", 32'(wb_cyc_o), 32'h1);
`endif

    @(negedge clk);
    req_cyc_i = 1'b1;
    req_we_i  = 1'b1;
    req_adr_i = 32'hF00;
    req_sel_i = 4'hf;
    req_dat_i = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_cyc", 32'(wb_cyc_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wb_cyc_o), 32'h0);
    chk("arst_stb", 32'(wb_stb_o), 32'h0);
    chk("arst_we", 32'(wb_we_o), 32'h0);
    chk("arst_adr", wb_adr_o, 32'h0);
    chk("arst_sel", 32'(wb_sel_o), 32'h0);
    chk("arst_dat", wb_dat_o, 32'h0);
    chk("arst_ack", 32'(req_ack_o), 32'h0);
    chk("arst_err", 32'(req_err_o), 32'h0);
    chk("arst_rdat", req_dat_o, 32'h0);
    req_cyc_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_ack_i = 1'b1;
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
    @(posedge clk); #1;
    chk("late_ack", 32'(req_ack_o), 32'h0);
    chk("late_cyc", 32'(wb_cyc_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
